// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, receiver state encoding and baud-timing derivation.
// The same derivation functions are used by the transmitter so both ends agree on bit timing.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud_rate);
    return clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high and idle-low lines can both use it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit qualified at mid-bit, data and stop sampled at bit centre.
// A framing error parks the FSM in WAIT_IDLE until the line goes high again.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF  = half_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_BITS);

  if (CPB < 4) begin : g_bad_cfg
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rx_s;
  logic                 cnt_half, cnt_last;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign cnt_half = (cnt == CNT_W'(HALF - 1));
  assign cnt_last = (cnt == CNT_W'(CPB - 1));
  assign rx_busy  = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt_half) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_last) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_nxt = ST_STOP;
          else                                  bit_idx_nxt = bit_idx + IDX_W'(1);
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop lets a start bit that follows with no gap be caught.
        if (cnt_last) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shreg        <= shreg_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: expected frames are queued as they
// are driven and popped by a monitor whenever rx_valid or rx_frame_err pulses.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] last_good = 8'h00;
  int         tests_run = 0;
  int         fails = 0;

  bit         meas = 0;
  bit         seen_high = 0;
  int         low_run = 0;
  int         runs[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every output pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reset && (rx_valid || rx_frame_err)) begin
      tests_run++;
      if (rx_valid && rx_frame_err) begin
        fails++;
        $display("FAIL excl: rx_valid and rx_frame_err both high, data=%h", rx_data);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected: valid=%0b frame_err=%0b data=%h, nothing expected",
                 rx_valid, rx_frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (e.err) begin
          if (!rx_frame_err || rx_data !== last_good) begin
            fails++;
            $display("FAIL frame_err: got valid=%0b err=%0b data=%h, want err=1 data=%h",
                     rx_valid, rx_frame_err, rx_data, last_good);
          end
        end else begin
          if (!rx_valid || rx_data !== e.data) begin
            fails++;
            $display("FAIL rx_byte: got valid=%0b err=%0b data=%h, want valid=1 data=%h",
                     rx_valid, rx_frame_err, rx_data, e.data);
          end
          last_good = e.data;
        end
      end
    end
  end

  // Records the length of each low stretch of rx_busy between two busy periods.
  always @(negedge clk) begin
    if (meas) begin
      if (rx_busy) begin
        if (seen_high && low_run > 0) runs.push_back(low_run);
        seen_high = 1;
        low_run   = 0;
      end else if (seen_high) begin
        low_run++;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    exp_t x;
    x.err  = 1'b0;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.err  = 1'b1;
    x.data = 8'h00;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s drain: %0d expected frames never arrived, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || rx_frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: data=%h valid=%b busy=%b err=%b, want 00 0 0 0",
               rx_data, rx_valid, rx_busy, rx_frame_err);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: busy=%b, want 0", rx_busy);
    end
  endtask

  task automatic test_loopback();
    push_byte(8'h9F);
    send_frame(8'h9F, 1'b1);
    idle(CPB);
    push_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    wait_drain("loopback");
  endtask

  task automatic test_back_to_back();
    runs.delete();
    seen_high = 0;
    low_run   = 0;
    meas      = 1;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'hA5);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    meas = 0;
    wait_drain("back_to_back");
    // Busy drops at mid-stop, so the gap is the rest of the stop bit up to the next start.
    tests_run++;
    if (runs.size() != 2) begin
      fails++;
      $display("FAIL b2b_gap_count: %0d busy-low gaps, want 2", runs.size());
    end else begin
      foreach (runs[i]) begin
        tests_run++;
        if (runs[i] != HALF) begin
          fails++;
          $display("FAIL b2b_gap_len[%0d]: busy low %0d cycles, want %0d", i, runs[i], HALF);
        end
      end
    end
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * CPB);
    tests_run++;
    if (rx_busy !== 1'b0 || rx_data !== last_good) begin
      fails++;
      $display("FAIL false_start: busy=%b data=%h, want busy=0 data=%h", rx_busy, rx_data, last_good);
    end
    push_byte(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(CPB);
    wait_drain("false_start");
  endtask

  task automatic test_frame_err();
    push_err();
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL ferr_busy_hold: busy=%b while line low, want 1", rx_busy);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL ferr_busy_early: busy=%b, want 1", rx_busy);
    end
    @(negedge clk);
    tests_run++;
    if (rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL ferr_busy_release: busy=%b, want 0", rx_busy);
    end
    wait_drain("frame_err");
    idle(CPB);
    push_byte(8'h81);
    send_frame(8'h81, 1'b1);
    idle(CPB);
    wait_drain("frame_err_recover");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d  = 8'hC3;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[4];
    repeat (HALF) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || rx_frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: data=%h valid=%b busy=%b err=%b, want 00 0 0 0",
               rx_data, rx_valid, rx_busy, rx_frame_err);
    end
    last_good = 8'h00;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2 * CPB);
    push_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    wait_drain("reset_mid_recover");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 1 ms");
    $fatal(1);
  end

endmodule
